// File: rtl/node_base_sched_pkg.sv
// Shared types, default parameters and helpers for the per-node base-ID scheduler.
package node_base_sched_pkg;

    localparam int LANES_DEF    = 2;
    localparam int BASE_LOG_DEF = 3;
    localparam int LAT_DD_DEF   = 2;
    localparam int LAT_RP_DEF   = 4;
    localparam int LAT_EX_DEF   = 6;

    typedef logic [BASE_LOG_DEF-1:0] base_id_t;

    // Operation accepted in the current cycle (after arbitration and the ready check).
    typedef enum logic [1:0] {
        OP_NONE   = 2'd0,
        OP_STEP   = 2'd1,
        OP_ROTATE = 2'd2
    } op_e;

    // Starting base ID of lane k: lanes are spread evenly over the base-ID space.
    function automatic int base_offset(input int k, input int lanes,
                                       input int base_log = BASE_LOG_DEF);
        return k * ((1 << base_log) / lanes);
    endfunction

endpackage

// File: rtl/node_base_sched_base_delay.sv
// Shift-register delay line: q_o is d_i delayed by DEPTH cycles. Reset and flush
// load every stage with rst_val_i so a flushed line reads as freshly reset.
module node_base_sched_base_delay #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] rst_val_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        assign q_o = d_i;
    end else begin : g_line
        logic [WIDTH-1:0] sh_q [DEPTH];

        // Shift one stage per cycle; reset/flush fill the whole line with the lane offset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) sh_q[i] <= rst_val_i;
            end else if (flush_i) begin
                for (int i = 0; i < DEPTH; i++) sh_q[i] <= rst_val_i;
            end else begin
                sh_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) sh_q[i] <= sh_q[i-1];
            end
        end

        assign q_o = sh_q[DEPTH-1];
    end

endmodule

// File: rtl/node_base_sched.sv
// Per-node scheduler producing rn/dd/rp/ex base IDs for LANES opt lanes.
// Handshake: a step or rotate is accepted only in a cycle where ready is high;
// ready then drops for LAT_EX cycles and returns together with a one-cycle done
// pulse in the first cycle the ex stage shows the result. Requests seen while
// ready is low are ignored and set the sticky err flag.
module node_base_sched
    import node_base_sched_pkg::*;
#(
    parameter int LANES    = LANES_DEF,
    parameter int BASE_LOG = BASE_LOG_DEF,
    parameter int LAT_DD   = LAT_DD_DEF,
    parameter int LAT_RP   = LAT_RP_DEF,
    parameter int LAT_EX   = LAT_EX_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic                      step,
    input  logic [LANES-1:0]          opt_en,
    input  logic                      rotate,
    output logic                      ready,
    output logic                      done,
    output logic                      err,
    output logic [LANES*BASE_LOG-1:0] rn_base_id,
    output logic [LANES*BASE_LOG-1:0] dd_base_id,
    output logic [LANES*BASE_LOG-1:0] rp_base_id,
    output logic [LANES*BASE_LOG-1:0] ex_base_id_r,
    output logic [LANES*BASE_LOG-1:0] ex_base_id_w
);

    localparam int CNT_W = $clog2(LAT_EX + 1);

    logic [BASE_LOG-1:0] off    [LANES];
    logic [BASE_LOG-1:0] rn_q   [LANES];
    logic [BASE_LOG-1:0] rn_d   [LANES];
    logic [BASE_LOG-1:0] dd_id  [LANES];
    logic [BASE_LOG-1:0] rp_id  [LANES];
    logic [BASE_LOG-1:0] ex_id  [LANES];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    op_e                 op;

    assign ready = (cnt_q == '0);
    assign done  = done_q;
    assign err   = err_q;

    // Arbitrate requests, compute next rn values and the handshake countdown.
    always_comb begin
        op     = OP_NONE;
        err_d  = err_q;
        rn_d   = rn_q;
        cnt_d  = cnt_q;
        done_d = (cnt_q == CNT_W'(1));

        if (step || rotate) begin
            if (!ready) begin
                err_d = 1'b1;
            end else if (step) begin
                op = OP_STEP;
                // A rotate arriving with a step loses and is flagged.
                if (rotate) err_d = 1'b1;
            end else begin
                op = OP_ROTATE;
            end
        end

        case (op)
            OP_STEP: begin
                for (int k = 0; k < LANES; k++) begin
                    if (opt_en[k]) rn_d[k] = rn_q[k] + BASE_LOG'(1);
                end
            end
            OP_ROTATE: begin
                for (int k = 0; k < LANES; k++) rn_d[k] = rn_q[(k + 1) % LANES];
            end
            default: ;
        endcase

        if (op != OP_NONE) begin
            cnt_d = CNT_W'(LAT_EX);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // init overrides everything, including a request in the same cycle.
        if (init) begin
            rn_d   = off;
            cnt_d  = '0;
            done_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    // rn counters and handshake state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LANES; k++) rn_q[k] <= off[k];
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rn_q   <= rn_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    // Per-lane stage delay lines: rn -> dd -> rp -> ex, chained so each stage
    // sits at its absolute latency from the rn update.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign off[k] = BASE_LOG'(base_offset(k, LANES, BASE_LOG));

        node_base_sched_base_delay #(.WIDTH(BASE_LOG), .DEPTH(LAT_DD)) u_dd (
            .clk      (clk),
            .rst_n    (reset),
            .flush_i  (init),
            .rst_val_i(off[k]),
            .d_i      (rn_q[k]),
            .q_o      (dd_id[k])
        );

        node_base_sched_base_delay #(.WIDTH(BASE_LOG), .DEPTH(LAT_RP - LAT_DD)) u_rp (
            .clk      (clk),
            .rst_n    (reset),
            .flush_i  (init),
            .rst_val_i(off[k]),
            .d_i      (dd_id[k]),
            .q_o      (rp_id[k])
        );

        node_base_sched_base_delay #(.WIDTH(BASE_LOG), .DEPTH(LAT_EX - LAT_RP)) u_ex (
            .clk      (clk),
            .rst_n    (reset),
            .flush_i  (init),
            .rst_val_i(off[k]),
            .d_i      (rp_id[k]),
            .q_o      (ex_id[k])
        );

        assign rn_base_id  [k*BASE_LOG +: BASE_LOG] = rn_q[k];
        assign dd_base_id  [k*BASE_LOG +: BASE_LOG] = dd_id[k];
        assign rp_base_id  [k*BASE_LOG +: BASE_LOG] = rp_id[k];
        assign ex_base_id_r[k*BASE_LOG +: BASE_LOG] = ex_id[k];
        // Write side addresses the successor lane's read ID.
        assign ex_base_id_w[k*BASE_LOG +: BASE_LOG] = ex_id[(k + 1) % LANES];
    end

endmodule

// File: tb/tb_node_base_sched.sv
// Self-checking bench for node_base_sched: directed scenarios followed by random
// traffic, all compared against a cycle-history reference model.
module tb_node_base_sched;

    localparam int LANES = 2;
    localparam int BL    = 3;
    localparam int BN    = 1 << BL;
    localparam int LDD   = 2;
    localparam int LRP   = 4;
    localparam int LEX   = 6;
    localparam int W     = LANES * BL;

    typedef logic [W-1:0] vec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             init = 1'b0;
    logic             step = 1'b0;
    logic [LANES-1:0] opt_en = '0;
    logic             rotate = 1'b0;
    logic             ready, done, err;
    logic [W-1:0]     rn_base_id, dd_base_id, rp_base_id, ex_base_id_r, ex_base_id_w;

    node_base_sched #(
        .LANES(LANES), .BASE_LOG(BL), .LAT_DD(LDD), .LAT_RP(LRP), .LAT_EX(LEX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .step        (step),
        .opt_en      (opt_en),
        .rotate      (rotate),
        .ready       (ready),
        .done        (done),
        .err         (err),
        .rn_base_id  (rn_base_id),
        .dd_base_id  (dd_base_id),
        .rp_base_id  (rp_base_id),
        .ex_base_id_r(ex_base_id_r),
        .ex_base_id_w(ex_base_id_w)
    );

    // clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: rn per lane, rn history (hist[d] = rn d cycles ago),
    // and the cycle of the last accepted operation
    int   m_rn [LANES];
    vec_t hist [$];
    bit   m_err;
    bit   m_have;
    int   m_acc;
    int   cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t pack_rn();
        vec_t v = '0;
        for (int k = 0; k < LANES; k++) v[k*BL +: BL] = BL'(m_rn[k]);
        return v;
    endfunction

    function automatic vec_t succ_lanes(input vec_t v);
        vec_t r = '0;
        for (int k = 0; k < LANES; k++) r[k*BL +: BL] = v[((k + 1) % LANES)*BL +: BL];
        return r;
    endfunction

    function automatic bit m_ready();
        return !m_have || (cyc >= m_acc + 1 + LEX);
    endfunction

    function automatic bit m_done();
        return m_have && (cyc == m_acc + 1 + LEX);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < LANES; k++) m_rn[k] = k * (BN / LANES);
        m_err  = 0;
        m_have = 0;
        hist.delete();
        for (int i = 0; i <= LEX; i++) hist.push_back(pack_rn());
    endtask

    // apply the inputs sampled at this clock edge to the model
    task automatic model_edge();
        int tmp [LANES];
        if (!reset || init) begin
            cyc++;
            model_reset();
            return;
        end
        if (step || rotate) begin
            if (!m_ready()) begin
                m_err = 1;
            end else begin
                m_have = 1;
                m_acc  = cyc;
                if (step) begin
                    if (rotate) m_err = 1;
                    for (int k = 0; k < LANES; k++)
                        if (opt_en[k]) m_rn[k] = (m_rn[k] + 1) % BN;
                end else begin
                    tmp = m_rn;
                    for (int k = 0; k < LANES; k++) m_rn[k] = tmp[(k + 1) % LANES];
                end
            end
        end
        cyc++;
        hist.push_front(pack_rn());
        void'(hist.pop_back());
    endtask

    task automatic check_all();
        chk("ready", 32'(ready), 32'(m_ready()));
        chk("done",  32'(done),  32'(m_done()));
        chk("err",   32'(err),   32'(m_err));
        chk("rn",    32'(rn_base_id),   32'(hist[0]));
        chk("dd",    32'(dd_base_id),   32'(hist[LDD]));
        chk("rp",    32'(rp_base_id),   32'(hist[LRP]));
        chk("ex_r",  32'(ex_base_id_r), 32'(hist[LEX]));
        chk("ex_w",  32'(ex_base_id_w), 32'(succ_lanes(hist[LEX])));
    endtask

    // driver: one clock, model update, then check #1 after the edge
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // wait (bounded) for ready, counting done pulses
    task automatic wait_ready(inout int ndone);
        for (int i = 0; i < 20 && !ready; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("ready_bound", 32'(ready), 32'd1);
    endtask

    task automatic issue(input logic s, input logic r, input logic [LANES-1:0] en);
        step = s; rotate = r; opt_en = en;
        tick();
        step = 1'b0; rotate = 1'b0;
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    initial begin
        int nd;

        // reset
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_rn", 32'(rn_base_id),   32'(6'b100_000));
        chk("rst_ex", 32'(ex_base_id_r), 32'(6'b100_000));
        chk("rst_rdy", 32'(ready), 32'd1);
        reset = 1'b1;
        tick();

        // single step on both lanes, watch it walk down the stages
        issue(1'b1, 1'b0, 2'b11);
        chk("step_rn", 32'(rn_base_id), 32'(6'b101_001));
        tick(); tick();
        chk("step_dd", 32'(dd_base_id), 32'(6'b101_001));
        tick(); tick();
        chk("step_rp", 32'(rp_base_id), 32'(6'b101_001));
        tick(); tick();
        chk("step_ex_r", 32'(ex_base_id_r), 32'(6'b101_001));
        chk("step_ex_w", 32'(ex_base_id_w), 32'(6'b001_101));
        chk("step_done", 32'(done), 32'd1);

        // eight steps on lane 0 only: wraps back to its offset
        do_init();
        nd = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 1'b0, 2'b01);
            wait_ready(nd);
        end
        chk("wrap_rn", 32'(rn_base_id), 32'(6'b100_000));
        chk("wrap_done_cnt", 32'(nd), 32'd8);

        // rotate from {4,1}
        do_init();
        nd = 0;
        issue(1'b1, 1'b0, 2'b01);
        wait_ready(nd);
        issue(1'b0, 1'b1, 2'b00);
        chk("rot_rn", 32'(rn_base_id), 32'(6'b001_100));
        nd = 0;
        wait_ready(nd);
        chk("rot_ex_r", 32'(ex_base_id_r), 32'(6'b001_100));
        chk("rot_done_cnt", 32'(nd), 32'd1);

        // step while busy: ignored, err sticky, init clears
        do_init();
        issue(1'b1, 1'b0, 2'b11);
        tick(); tick();
        issue(1'b1, 1'b0, 2'b11);
        chk("busy_err", 32'(err), 32'd1);
        nd = 0;
        wait_ready(nd);
        chk("busy_rn", 32'(rn_base_id), 32'(6'b101_001));
        do_init();
        chk("init_err", 32'(err), 32'd0);
        chk("init_rn", 32'(rn_base_id), 32'(6'b100_000));

        // step + rotate together: step wins, err set
        issue(1'b1, 1'b1, 2'b01);
        chk("sr_err", 32'(err), 32'd1);
        nd = 0;
        wait_ready(nd);
        chk("sr_rn", 32'(ex_base_id_r), 32'(6'b100_001));

        // step and init in the same cycle: init wins, no done
        do_init();
        step = 1'b1; init = 1'b1; opt_en = 2'b11;
        tick();
        step = 1'b0; init = 1'b0;
        nd = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (done) nd++; end
        chk("si_done_cnt", 32'(nd), 32'd0);
        chk("si_rn", 32'(rn_base_id), 32'(6'b100_000));

        // async reset in the middle of a countdown
        issue(1'b1, 1'b0, 2'b11);
        tick(); tick();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 10; i++) begin tick(); if (done) nd++; end
        chk("mrst_done_cnt", 32'(nd), 32'd0);
        chk("mrst_rdy", 32'(ready), 32'd1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step   = ($urandom_range(0, 3) == 0);
            rotate = ($urandom_range(0, 5) == 0);
            init   = ($urandom_range(0, 60) == 0);
            opt_en = LANES'($urandom_range(0, (1 << LANES) - 1));
            tick();
        end
        step = 1'b0; rotate = 1'b0; init = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
